// File: rtl/crc8_frame_checker_if.sv
// crc8_frame_checker_if: byte stream, frame result and status signals of the CRC-8 frame checker
interface crc8_frame_checker_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       abort;
    logic [7:0] payload_out;
    logic       payload_valid;
    logic       frame_done;
    logic       frame_ok;
    logic [7:0] crc_out;
    logic       busy;
    modport master (
        output data_in, data_valid, abort,
        input  data_ready, payload_out, payload_valid, frame_done, frame_ok, crc_out, busy
    );
    modport slave (
        input  data_in, data_valid, abort,
        output data_ready, payload_out, payload_valid, frame_done, frame_ok, crc_out, busy
    );
endinterface

// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: checks length-prefixed frames against a trailing CRC-8, one CRC bit per cycle
module crc8_frame_checker #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input logic clock,
    input logic reset,
    crc8_frame_checker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CALC, PAYLOAD, CHECK, REPORT} state_t;
    state_t     state, state_next;
    logic [7:0] crc, remaining;
    logic [2:0] bit_cnt;
    logic       xfer, kill;
    assign xfer = bus.data_valid && bus.data_ready;
    assign kill = bus.abort && state != IDLE;
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_next;
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = xfer ? CALC : IDLE;
            CALC:    state_next = bit_cnt != 3'd7 ? CALC : remaining == 8'd0 ? CHECK : PAYLOAD;
            PAYLOAD: state_next = xfer ? CALC : PAYLOAD;
            CHECK:   state_next = xfer ? REPORT : CHECK;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill)
            state_next = IDLE;
    end
    always_comb begin
        bus.data_ready = state == IDLE || state == PAYLOAD || state == CHECK;
        bus.busy       = state != IDLE;
        bus.frame_done = state == REPORT;
    end
    // an aborted cycle leaves every register untouched, so the offered byte is dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            crc               <= 8'd0;
            remaining         <= 8'd0;
            bit_cnt           <= 3'd0;
            bus.payload_out   <= 8'd0;
            bus.payload_valid <= 1'b0;
            bus.frame_ok      <= 1'b0;
            bus.crc_out       <= 8'd0;
        end else begin
            bus.payload_valid <= 1'b0;
            if (!kill) begin
                unique case (state)
                    IDLE: if (xfer) begin
                        crc       <= INIT ^ bus.data_in;
                        remaining <= bus.data_in;
                        bit_cnt   <= 3'd0;
                    end
                    CALC: begin
                        crc     <= crc[7] ? {crc[6:0], 1'b0} ^ POLY : {crc[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PAYLOAD: if (xfer) begin
                        crc               <= crc ^ bus.data_in;
                        remaining         <= remaining == 8'd0 ? 8'd0 : remaining - 8'd1;
                        bus.payload_out   <= bus.data_in;
                        bus.payload_valid <= 1'b1;
                    end
                    CHECK: if (xfer) begin
                        bus.frame_ok <= bus.data_in == crc;
                        bus.crc_out  <= crc;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb_crc8_frame_checker: vector table, corner sequences and random frames against a polynomial-division model
module tb_crc8_frame_checker;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;
    crc8_frame_checker_if bus();
    crc8_frame_checker #(.POLY(8'h07), .INIT(8'h00)) dut (.clock(clock), .reset(reset), .bus(bus));
    typedef struct {
        int         n;
        logic [7:0] b [4];
        logic       ok;
        logic [7:0] crc;
    } vec_t;
    vec_t       vt [5];
    int         n_err = 0, n_checks = 0;
    int         fd_seen = 0;
    logic       last_ok;
    logic [7:0] last_crc;
    logic [7:0] exp_pl [$];
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask
    // reference CRC: remainder of message * x^8 modulo x^8 + x^2 + x + 1
    function automatic logic [7:0] ref_crc(input logic [7:0] msg [$]);
        logic [8:0] r = 9'd0;
        foreach (msg[k])
            for (int i = 7; i >= 0; i--) begin
                r = {r[7:0], msg[k][i]};
                if (r[8]) r ^= 9'h107;
            end
        for (int i = 0; i < 8; i++) begin
            r = {r[7:0], 1'b0};
            if (r[8]) r ^= 9'h107;
        end
        return r[7:0];
    endfunction
    always @(negedge clock) if (!reset) begin
        if (bus.payload_valid) begin
            if (exp_pl.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL payload_unexpected: got %0h expected none at %0t", bus.payload_out, $time);
            end else
                check("payload_out", bus.payload_out, exp_pl.pop_front());
        end
        if (bus.frame_done) begin
            fd_seen++;
            last_ok  = bus.frame_ok;
            last_crc = bus.crc_out;
        end
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic send_byte(input logic [7:0] b, input bit hold);
        int t = 0;
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        while (!bus.data_ready && t < 100) begin
            tick(1);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 at %0t", $time);
        end
        tick(1);
        if (!hold) bus.data_valid = 1'b0;
    endtask
    task automatic wait_done(input int start);
        int t = 0;
        while (fd_seen == start && t < 40) begin
            tick(1);
            t++;
        end
        check("frame_done_seen", fd_seen, start + 1);
    endtask
    task automatic count_busy(input string name);
        int c = 0;
        while (!bus.data_ready && c < 20) begin
            c++;
            tick(1);
        end
        check(name, c, 8);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int start;
        logic [7:0] msg [$];
        logic [7:0] c, rx, prev_crc;
        logic prev_ok;
        int n, abort_at;
        bit aborted;
        vt[0] = '{2, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 8'h00};
        vt[1] = '{2, '{8'h00, 8'h01, 8'h00, 8'h00}, 1'b0, 8'h00};
        vt[2] = '{3, '{8'h01, 8'h31, 8'h82, 8'h00}, 1'b1, 8'h82};
        vt[3] = '{3, '{8'h01, 8'h31, 8'h00, 8'h00}, 1'b0, 8'h82};
        vt[4] = '{3, '{8'h01, 8'h00, 8'h15, 8'h00}, 1'b1, 8'h15};
        reset = 1'b1;
        bus.data_in = 8'h00;
        bus.data_valid = 1'b0;
        bus.abort = 1'b0;
        tick(3);
        check("rst_payload_out", bus.payload_out, 0);
        check("rst_crc_out", bus.crc_out, 0);
        check("rst_frame_ok", bus.frame_ok, 0);
        check("rst_payload_valid", bus.payload_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.data_ready, 1);
        for (int v = 0; v < 5; v++) begin
            start = fd_seen;
            for (int i = 1; i < vt[v].n - 1; i++) exp_pl.push_back(vt[v].b[i]);
            for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].b[i], 1'b0);
            check($sformatf("vec%0d_done_latency", v), bus.frame_done, 1);
            wait_done(start);
            check($sformatf("vec%0d_ok", v), last_ok, vt[v].ok);
            check($sformatf("vec%0d_crc", v), last_crc, vt[v].crc);
            check($sformatf("vec%0d_pl_left", v), exp_pl.size(), 0);
        end
        // data_valid held high through the whole frame
        start = fd_seen;
        exp_pl.push_back(8'h31);
        send_byte(8'h01, 1'b1);
        count_busy("hold_ready_low_len");
        send_byte(8'h31, 1'b1);
        count_busy("hold_ready_low_pl");
        send_byte(8'h82, 1'b0);
        wait_done(start);
        check("hold_ok", last_ok, 1);
        check("hold_crc", last_crc, 8'h82);
        check("hold_pl_left", exp_pl.size(), 0);
        // abort in CALC after the payload byte
        start = fd_seen;
        exp_pl.push_back(8'h31);
        send_byte(8'h01, 1'b0);
        send_byte(8'h31, 1'b0);
        tick(3);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        tick(12);
        check("abort_no_done", fd_seen, start);
        check("abort_keep_crc", bus.crc_out, 8'h82);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done(start);
        check("after_abort_ok", last_ok, 1);
        check("after_abort_crc", last_crc, 8'h00);
        // abort in CHECK together with an offered CRC byte: byte is dropped
        start = fd_seen;
        send_byte(8'h00, 1'b0);
        for (int t = 0; t < 20 && !bus.data_ready; t++) tick(1);
        bus.data_in = 8'h55;
        bus.data_valid = 1'b1;
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        bus.data_valid = 1'b0;
        check("abort_check_busy", bus.busy, 0);
        tick(4);
        check("abort_check_no_done", fd_seen, start);
        check("abort_check_keep_ok", bus.frame_ok, 1);
        // reset in PAYLOAD
        exp_pl.push_back(8'h11);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        for (int t = 0; t < 20 && !bus.data_ready; t++) tick(1);
        reset = 1'b1;
        exp_pl.delete();
        tick(1);
        reset = 1'b0;
        check("mid_rst_payload_out", bus.payload_out, 0);
        check("mid_rst_crc_out", bus.crc_out, 0);
        check("mid_rst_frame_ok", bus.frame_ok, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.data_ready, 1);
        start = fd_seen;
        exp_pl.push_back(8'h31);
        send_byte(8'h01, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h82, 1'b0);
        wait_done(start);
        check("after_rst_ok", last_ok, 1);
        check("after_rst_crc", last_crc, 8'h82);
        // random frames, some corrupted, some aborted
        for (int f = 0; f < 40; f++) begin
            n = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 6);
            msg = {};
            msg.push_back(n[7:0]);
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
            c = ref_crc(msg);
            rx = $urandom_range(0, 1) ? c : c ^ 8'($urandom_range(1, 255));
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n + 1) : -1;
            start = fd_seen;
            prev_ok = bus.frame_ok;
            prev_crc = bus.crc_out;
            aborted = 1'b0;
            for (int i = 0; i <= n + 1 && !aborted; i++) begin
                if (i >= 1 && i <= n) exp_pl.push_back(msg[i]);
                tick($urandom_range(0, 2));
                send_byte(i <= n ? msg[i] : rx, 1'b0);
                if (i + 1 == abort_at) begin
                    tick($urandom_range(0, 6));
                    bus.abort = 1'b1;
                    tick(1);
                    bus.abort = 1'b0;
                    aborted = 1'b1;
                end
            end
            if (aborted) begin
                check($sformatf("rnd%0d_abort_busy", f), bus.busy, 0);
                tick(2);
                check($sformatf("rnd%0d_abort_no_done", f), fd_seen, start);
                check($sformatf("rnd%0d_abort_keep", f), {bus.frame_ok, bus.crc_out}, {prev_ok, prev_crc});
            end else begin
                wait_done(start);
                check($sformatf("rnd%0d_ok", f), last_ok, rx == c);
                check($sformatf("rnd%0d_crc", f), last_crc, c);
            end
            check($sformatf("rnd%0d_pl_left", f), exp_pl.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial without the implicit x^8 term.
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register value at start of each frame.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  incoming frame byte.
REQ-006 SHALL have port data_valid  input  1  data_in holds a byte offered for transfer.
REQ-007 SHALL have port data_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port abort  input  1  synchronous frame abort.
REQ-009 SHALL have port payload_out  output  8  last accepted payload byte.
REQ-010 SHALL have port payload_valid  output  1  one-cycle pulse: payload_out updated.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse: frame check complete.
REQ-012 SHALL have port frame_ok  output  1  result of the last completed frame.
REQ-013 SHALL have port crc_out  output  8  CRC computed over the last completed frame.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL use frame format: length byte N (0-255), then N payload bytes, then one received-CRC byte.
REQ-016 SHALL compute CRC over the length byte and payload bytes, MSB-first, unreflected, no final XOR; the received-CRC byte is excluded.
REQ-017 SHALL transfer a byte on a rising edge where data_valid=1 and data_ready=1; data_valid while data_ready=0 is ignored and nothing is consumed.
REQ-018 SHALL implement states IDLE, CALC, PAYLOAD, CHECK, REPORT.
REQ-019 IDLE: data_ready=1; on transfer, crc<=INIT^data_in, remaining<=data_in, bit counter<=0, next state CALC.
REQ-020 CALC: data_ready=0; one bit step per cycle: if crc[7], crc<=(crc<<1)^POLY, else crc<=crc<<1; stays exactly 8 cycles.
REQ-021 CALC exit after the 8th step: remaining==0 -> CHECK, else -> PAYLOAD.
REQ-022 PAYLOAD: data_ready=1; on transfer, crc<=crc^data_in, remaining<=remaining-1, payload_out<=data_in, payload_valid=1 for the next cycle, next state CALC.
REQ-023 CHECK: data_ready=1; on transfer, frame_ok<=(data_in==crc), crc_out<=crc, next state REPORT.
REQ-024 REPORT: data_ready=0, frame_done=1 for this single cycle, next state IDLE.
REQ-025 Timing: data_ready SHALL be low for exactly 8 cycles after each length or payload transfer; maximum throughput is one byte per 9 cycles.
REQ-026 Length 0: the frame SHALL be the length byte followed directly by the CRC byte, with no payload_valid pulse.
REQ-027 remaining SHALL be 8 bits and never decrement below 0.
REQ-028 abort=1 in any state SHALL force IDLE at the next edge, with no frame_done pulse; frame_ok and crc_out keep their prior values; a byte offered in the same cycle is discarded.
REQ-029 reset SHALL take priority over abort; abort in IDLE SHALL have no effect.
REQ-030 frame_ok and crc_out SHALL hold until the next frame_done.

Reset
REQ-031 While reset=1, state SHALL go to IDLE at the next edge; crc, remaining and the bit counter SHALL go to 0.
REQ-032 While reset=1, payload_out, crc_out, frame_ok, payload_valid and frame_done SHALL go to 0.
REQ-033 After reset, busy SHALL be 0 and data_ready SHALL be 1 from the first cycle following reset deassertion.
REQ-034 Reset mid-frame SHALL discard the frame with no frame_done pulse.

Verification
REQ-035 Frame {0x00, 0x00} -> frame_done one cycle after the CRC transfer, frame_ok=1, crc_out=0x00, no payload_valid.
REQ-036 Frame {0x00, 0x01} -> frame_ok=0, crc_out=0x00.
REQ-037 Frame {0x01, 0x31, 0x82} -> one payload_valid with payload_out=0x31, frame_ok=1, crc_out=0x82.
REQ-038 Frame {0x01, 0x31, 0x82} with data_valid held high -> data_ready low for exactly 8 cycles after each of the first two transfers; bytes held during those cycles are not consumed twice.
REQ-039 abort pulsed during CALC after the payload byte, then frame {0x00, 0x00} sent -> no frame_done for the aborted frame; second frame gives frame_ok=1.
REQ-040 reset asserted in PAYLOAD state -> all outputs 0, busy=0, data_ready=1 after release; next frame checked correctly.
